la_bec_ctrl: RTL and testbench

LA_BEC_CTRL -- requirements
Module: la_bec_ctrl

---
 rtl/la_bec_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_la_bec_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_bec_ctrl.sv
// ---------------------------------------------------------------------------
// la_bec_ctrl
//
// Bridges the management core's logic-analyser (LA) port to a BEC compute
// core. The management core pushes N_IN operand words over a four-phase
// req/ack handshake. The block fires a one-cycle start pulse at the core and
// waits for its completion pulse, giving up after TIMEOUT cycles. The host
// then pulls N_OUT result words back over the same handshake.
//
// Ports
//   clock       : single clock, everything on its rising edge
//   resetb      : asynchronous active-low reset
//   la_req      : four-phase request from the management core
//   la_wdata    : operand word, valid while la_req is high
//   la_abort    : synchronous abort, returns the block to IDLE
//   la_ack      : four-phase acknowledge
//   la_rdata    : registered result word presented during UNLOAD
//   status      : registered status code of the current state
//   busy        : high while the core owns the job (START / PROC)
//   irq         : high once a job has finished or failed (DONE / ERR)
//   core_din    : operand bus to the core, word k at [32k+31:32k]
//   core_start  : one-cycle start pulse to the core
//   core_done   : one-cycle completion pulse from the core
//   core_dout   : result bus from the core, word k at [32k+31:32k]
// ---------------------------------------------------------------------------
module la_bec_ctrl #(
    parameter int N_IN    = 6,
    parameter int N_OUT   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic                  clock,
    input  logic                  resetb,
    input  logic                  la_req,
    input  logic [31:0]           la_wdata,
    input  logic                  la_abort,
    output logic                  la_ack,
    output logic [31:0]           la_rdata,
    output logic [15:0]           status,
    output logic                  busy,
    output logic                  irq,
    output logic [N_IN*32-1:0]    core_din,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [N_OUT*32-1:0]   core_dout
);

    localparam int IN_W  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
    localparam int OUT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int IDX_W = (IN_W > OUT_W) ? IN_W : OUT_W;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] IN_LAST  = IDX_W'(N_IN - 1);
    localparam logic [IDX_W-1:0] OUT_LAST = IDX_W'(N_OUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [15:0] CODE_IDLE   = 16'hAB40;
    localparam logic [15:0] CODE_LOAD   = 16'hAB41;
    localparam logic [15:0] CODE_PROC   = 16'hAB42;
    localparam logic [15:0] CODE_UNLOAD = 16'hAB51;
    localparam logic [15:0] CODE_DONE   = 16'hAB43;
    localparam logic [15:0] CODE_ERR    = 16'hAB44;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_PROC,
        ST_UNLOAD,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               run_en;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_next;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic               ack_next;
    logic [15:0]        status_next;
    logic               cap_word;
    logic               cap_result;
    logic               load_rdata;
    logic [IN_W-1:0]    cap_sel;
    logic [OUT_W-1:0]   rd_sel;
    logic [31:0]        din_q [N_IN];
    logic [31:0]        res_q [N_OUT];

    // START and PROC share a status code; the host only needs to know the
    // core owns the job, not whether the start pulse is still in flight.
    function automatic logic [15:0] code_of(input state_t s);
        case (s)
            ST_IDLE:   code_of = CODE_IDLE;
            ST_LOAD:   code_of = CODE_LOAD;
            ST_START:  code_of = CODE_PROC;
            ST_PROC:   code_of = CODE_PROC;
            ST_UNLOAD: code_of = CODE_UNLOAD;
            ST_DONE:   code_of = CODE_DONE;
            ST_ERR:    code_of = CODE_ERR;
            default:   code_of = CODE_IDLE;
        endcase
    endfunction

    // The operand capture index is the index the word will live at after this
    // edge, so the job-start case (idx forced to 0) and the in-LOAD case share
    // one write port.
    assign cap_sel = idx_next[IN_W-1:0];
    assign rd_sel  = idx[OUT_W-1:0];

    // Reset release gate: the FSM is held for the first edge after resetb
    // rises, so the earliest state change lands on the second edge.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            run_en <= 1'b0;
        end else begin
            run_en <= 1'b1;
        end
    end

    // Next-state and handshake decode. Abort outranks every other event, and
    // core_done outranks the terminal count so a late-but-valid result is kept.
    always_comb begin
        next_state = state;
        ack_next   = la_ack;
        idx_next   = idx;
        cnt_next   = cnt;
        cap_word   = 1'b0;
        cap_result = 1'b0;
        load_rdata = 1'b0;

        if (!run_en) begin
            next_state = state;
        end else if (la_abort) begin
            next_state = ST_IDLE;
            ack_next   = 1'b0;
            idx_next   = '0;
            cnt_next   = '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (la_req && !la_ack) begin
                        next_state = ST_LOAD;
                        idx_next   = '0;
                        cap_word   = 1'b1;
                        ack_next   = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (la_req && !la_ack) begin
                        ack_next = 1'b1;
                        cap_word = 1'b1;
                    end else if (la_ack && !la_req) begin
                        ack_next = 1'b0;
                        if (idx == IN_LAST) begin
                            next_state = ST_START;
                            idx_next   = '0;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end
                end
                ST_START: begin
                    next_state = ST_PROC;
                    cnt_next   = '0;
                end
                ST_PROC: begin
                    if (core_done) begin
                        cap_result = 1'b1;
                        idx_next   = '0;
                        next_state = ST_UNLOAD;
                    end else if (cnt == CNT_LAST) begin
                        cnt_next   = cnt + 1'b1;
                        next_state = ST_ERR;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (la_req && !la_ack) begin
                        ack_next   = 1'b1;
                        load_rdata = 1'b1;
                    end else if (la_ack && !la_req) begin
                        ack_next = 1'b0;
                        if (idx == OUT_LAST) begin
                            next_state = ST_DONE;
                            idx_next   = '0;
                        end else begin
                            idx_next = idx + 1'b1;
                        end
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                    ack_next   = 1'b0;
                    idx_next   = '0;
                    cnt_next   = '0;
                end
            endcase
        end

        status_next = code_of(next_state);
    end

    // Control registers. Status is loaded from the next state so it always
    // matches the state register without an extra cycle of lag.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state  <= ST_IDLE;
            status <= CODE_IDLE;
            la_ack <= 1'b0;
            idx    <= '0;
            cnt    <= '0;
        end else begin
            state  <= next_state;
            status <= status_next;
            la_ack <= ack_next;
            idx    <= idx_next;
            cnt    <= cnt_next;
        end
    end

    // Operand and result storage. Abort deliberately leaves both untouched so
    // the host can inspect what was loaded or computed before the abort.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int k = 0; k < N_IN; k++) begin
                din_q[k] <= '0;
            end
            for (int k = 0; k < N_OUT; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            if (cap_word) begin
                din_q[cap_sel] <= la_wdata;
            end
            if (cap_result) begin
                for (int k = 0; k < N_OUT; k++) begin
                    res_q[k] <= core_dout[32*k +: 32];
                end
            end
        end
    end

    // Read data is loaded on the same edge that raises la_ack, so the host
    // never sees ack before the word it acknowledges. It holds otherwise.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            la_rdata <= '0;
        end else if (load_rdata) begin
            la_rdata <= res_q[rd_sel];
        end
    end

    for (genvar k = 0; k < N_IN; k++) begin : g_din
        assign core_din[32*k +: 32] = din_q[k];
    end

    assign core_start = (state == ST_START);
    assign busy       = (state == ST_START) || (state == ST_PROC);
    assign irq        = (state == ST_DONE)  || (state == ST_ERR);

endmodule

// File: tb/tb_la_bec_ctrl.sv
// ---------------------------------------------------------------------------
// tb_la_bec_ctrl
//
// Self-checking bench for la_bec_ctrl. A small host model drives the LA
// four-phase handshake and a small core model answers core_start. Expected
// operand and result words are queued when they are driven and popped when
// the DUT presents them.
// ---------------------------------------------------------------------------
module tb_la_bec_ctrl;

    localparam int N_IN     = 6;
    localparam int N_OUT    = 4;
    localparam int TIMEOUT  = 64;
    localparam int WAIT_MAX = 50;

    logic                 clock     = 1'b0;
    logic                 resetb    = 1'b0;
    logic                 la_req    = 1'b0;
    logic [31:0]          la_wdata  = '0;
    logic                 la_abort  = 1'b0;
    logic                 core_done = 1'b0;
    logic [N_OUT*32-1:0]  core_dout = '0;
    logic                 la_ack;
    logic [31:0]          la_rdata;
    logic [15:0]          status;
    logic                 busy;
    logic                 irq;
    logic [N_IN*32-1:0]   core_din;
    logic                 core_start;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] din_q [$];
    logic [31:0] rd_q  [$];

    la_bec_ctrl #(
        .N_IN    (N_IN),
        .N_OUT   (N_OUT),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock      (clock),
        .resetb     (resetb),
        .la_req     (la_req),
        .la_wdata   (la_wdata),
        .la_abort   (la_abort),
        .la_ack     (la_ack),
        .la_rdata   (la_rdata),
        .status     (status),
        .busy       (busy),
        .irq        (irq),
        .core_din   (core_din),
        .core_start (core_start),
        .core_done  (core_done),
        .core_dout  (core_dout)
    );

    always #5 clock = ~clock;

    // Hard stop in case something upstream wedges the handshake loops.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Waits, bounded, for la_ack to reach the requested level.
    task automatic wait_ack(input logic level, input string what);
        int n;
        n = 0;
        while (la_ack !== level && n < WAIT_MAX) begin
            @(negedge clock);
            n++;
        end
        if (la_ack !== level) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: la_ack=%b required %b", what, la_ack, level);
        end
    endtask

    // One complete four-phase write of an operand word.
    task automatic host_write(input logic [31:0] w);
        @(negedge clock);
        la_wdata = w;
        la_req   = 1'b1;
        wait_ack(1'b1, "write_ack_rise");
        la_req   = 1'b0;
        la_wdata = $urandom;
        wait_ack(1'b0, "write_ack_fall");
    endtask

    // One complete four-phase read of a result word.
    task automatic host_read(output logic [31:0] d);
        @(negedge clock);
        la_wdata = $urandom;
        la_req   = 1'b1;
        wait_ack(1'b1, "read_ack_rise");
        d        = la_rdata;
        la_req   = 1'b0;
        wait_ack(1'b0, "read_ack_fall");
    endtask

    // Loads operand words first..N_IN-1 of base+k, optionally queueing them.
    task automatic load_words(input logic [31:0] base, input int first, input bit push);
        for (int k = first; k < N_IN; k++) begin
            if (push) din_q.push_back(base + k);
            host_write(base + k);
        end
    endtask

    // Called in the START cycle: checks the start pulse and operands, answers
    // after 'delay' cycles with results res_base+k, then unloads and checks.
    task automatic finish_job(input logic [31:0] res_base, input int delay, input string name);
        int          pulses;
        logic [31:0] got;
        logic [31:0] exp;
        checks++;
        if (core_start !== 1'b1 || status !== 16'hAB42) begin
            errors++;
            $display("[TB] FAIL %s_start: core_start=%b status=%h required 1 / ab42", name, core_start, status);
        end
        pulses = (core_start === 1'b1) ? 1 : 0;
        for (int k = 0; k < N_IN; k++) begin
            exp = din_q.pop_front();
            checks++;
            if (core_din[32*k +: 32] !== exp) begin
                errors++;
                $display("[TB] FAIL %s_din%0d: got %h required %h", name, k, core_din[32*k +: 32], exp);
            end
        end
        for (int c = 0; c < delay; c++) begin
            @(negedge clock);
            if (core_start === 1'b1) pulses++;
        end
        checks++;
        if (status !== 16'hAB42 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_proc: status=%h busy=%b required ab42 / 1", name, status, busy);
        end
        core_done = 1'b1;
        for (int k = 0; k < N_OUT; k++) begin
            core_dout[32*k +: 32] = res_base + k;
            rd_q.push_back(res_base + k);
        end
        @(negedge clock);
        core_done = 1'b0;
        core_dout = '0;
        checks++;
        if (status !== 16'hAB51 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s_unload: status=%h busy=%b required ab51 / 0", name, status, busy);
        end
        for (int k = 0; k < N_OUT; k++) begin
            host_read(got);
            exp = rd_q.pop_front();
            checks++;
            if (got !== exp) begin
                errors++;
                $display("[TB] FAIL %s_rd%0d: got %h required %h", name, k, got, exp);
            end
        end
        checks++;
        if (status !== 16'hAB43 || irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done: status=%h irq=%b required ab43 / 1", name, status, irq);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("[TB] FAIL %s_pulses: got %0d required 1", name, pulses);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (la_rdata !== res_base + N_OUT - 1) begin
            errors++;
            $display("[TB] FAIL %s_rdata_hold: got %h required %h", name, la_rdata, res_base + N_OUT - 1);
        end
    endtask

    // Reset values, then a release with la_req already high: the first edge
    // after release must not move the FSM.
    task automatic test_reset();
        repeat (3) @(negedge clock);
        checks++;
        if (status !== 16'hAB40 || la_ack !== 1'b0 || la_rdata !== 32'h0 || core_start !== 1'b0 ||
            core_din !== '0 || busy !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_values: status=%h ack=%b rdata=%h start=%b busy=%b irq=%b required ab40 and zeros",
                     status, la_ack, la_rdata, core_start, busy, irq);
        end
        la_wdata = 32'hDEAD_BEEF;
        la_req   = 1'b1;
        resetb   = 1'b1;
        @(negedge clock);
        checks++;
        if (status !== 16'hAB40 || la_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: status=%h ack=%b required ab40 / 0", status, la_ack);
        end
        la_req = 1'b0;
        @(negedge clock);
        checks++;
        if (status !== 16'hAB40) begin
            errors++;
            $display("[TB] FAIL reset_idle: status=%h required ab40", status);
        end
    endtask

    task automatic test_normal_job();
        din_q.push_back(32'h1000_0000);
        host_write(32'h1000_0000);
        checks++;
        if (status !== 16'hAB41 || la_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL normal_load: status=%h ack=%b required ab41 / 0", status, la_ack);
        end
        load_words(32'h1000_0000, 1, 1'b1);
        finish_job(32'h0000_00A0, 20, "normal");
    endtask

    // The core never answers; PROC must last exactly TIMEOUT cycles.
    task automatic test_timeout();
        int proc;
        load_words(32'h2000_0000, 0, 1'b0);
        checks++;
        if (core_start !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_start: core_start=%b required 1", core_start);
        end
        proc = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (status === 16'hAB42) proc++;
            else break;
        end
        checks++;
        if (proc != TIMEOUT) begin
            errors++;
            $display("[TB] FAIL timeout_cycles: got %0d required %0d", proc, TIMEOUT);
        end
        checks++;
        if (status !== 16'hAB44 || la_ack !== 1'b0 || irq !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL timeout_err: status=%h ack=%b irq=%b busy=%b required ab44 0 1 0",
                     status, la_ack, irq, busy);
        end
    endtask

    // core_done lands on the terminal-count cycle; done must win.
    task automatic test_coincident();
        load_words(32'h3000_0000, 0, 1'b1);
        finish_job(32'h0000_00B0, TIMEOUT, "coincident");
    endtask

    task automatic test_abort();
        int pulses;
        host_write(32'h4000_0000);
        host_write(32'h4000_0001);
        @(negedge clock);
        la_wdata = 32'h4000_0002;
        la_req   = 1'b1;
        wait_ack(1'b1, "abort_ack_rise");
        la_abort = 1'b1;
        @(negedge clock);
        checks++;
        if (status !== 16'hAB40 || la_ack !== 1'b0) begin
            errors++;
            $display("[TB] FAIL abort_idle: status=%h ack=%b required ab40 / 0", status, la_ack);
        end
        checks++;
        if (core_din[31:0] !== 32'h4000_0000 || core_din[95:64] !== 32'h4000_0002) begin
            errors++;
            $display("[TB] FAIL abort_retain: w0=%h w2=%h required 40000000 / 40000002",
                     core_din[31:0], core_din[95:64]);
        end
        la_abort = 1'b0;
        la_req   = 1'b0;
        pulses   = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (core_start === 1'b1 || status !== 16'hAB40) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("[TB] FAIL abort_quiet: got %0d active cycles required 0", pulses);
        end
        load_words(32'h5000_0000, 0, 1'b1);
        finish_job(32'h0000_00C0, 5, "after_abort");
    endtask

    // New request straight out of DONE: LOAD, word 0 and ack on one edge.
    task automatic test_back_to_back();
        @(negedge clock);
        la_wdata = 32'h6000_0000;
        la_req   = 1'b1;
        din_q.push_back(32'h6000_0000);
        @(negedge clock);
        checks++;
        if (status !== 16'hAB41 || la_ack !== 1'b1 || core_din[31:0] !== 32'h6000_0000) begin
            errors++;
            $display("[TB] FAIL b2b_entry: status=%h ack=%b w0=%h required ab41 1 60000000",
                     status, la_ack, core_din[31:0]);
        end
        la_req = 1'b0;
        wait_ack(1'b0, "b2b_ack_fall");
        load_words(32'h6000_0000, 1, 1'b1);
        finish_job(32'h0000_00D0, 10, "b2b");
    endtask

    task automatic test_reset_mid_proc();
        int active;
        load_words(32'h7000_0000, 0, 1'b0);
        repeat (5) @(negedge clock);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midreset_busy: busy=%b required 1", busy);
        end
        #2 resetb = 1'b0;
        #1;
        checks++;
        if (status !== 16'hAB40 || la_ack !== 1'b0 || la_rdata !== 32'h0 || core_start !== 1'b0 ||
            core_din !== '0 || busy !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_values: status=%h ack=%b rdata=%h start=%b busy=%b irq=%b required ab40 and zeros",
                     status, la_ack, la_rdata, core_start, busy, irq);
        end
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        core_done = 1'b1;
        core_dout = {N_OUT{32'hE0E0_E0E0}};
        @(negedge clock);
        core_done = 1'b0;
        core_dout = '0;
        active    = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            if (core_start === 1'b1 || status !== 16'hAB40 || busy !== 1'b0) active++;
        end
        checks++;
        if (active != 0 || la_rdata !== 32'h0) begin
            errors++;
            $display("[TB] FAIL midreset_quiet: active=%0d rdata=%h required 0 / 0", active, la_rdata);
        end
    endtask

    initial begin
        $display("[TB] la_bec_ctrl bench starting");
        test_reset();
        test_normal_job();
        test_timeout();
        test_coincident();
        test_abort();
        test_back_to_back();
        test_reset_mid_proc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
